// File: rtl/gtrg_readout_seq_pkg.sv
// gtrg_readout_seq_pkg: states, word tags, grant indices and the majority vote shared by the readout sequencer
package gtrg_readout_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RD, S_LATCH, S_HDR, S_SCAN, S_WAIT_DN, S_TRL
  } state_t;
  localparam logic [3:0] TAG_L1A = 4'h9;
  localparam logic [3:0] TAG_BX = 4'hA;
  localparam logic [3:0] TAG_TRL = 4'hF;
  localparam logic [3:0] TAG_FLG = 4'hE;
  localparam int GNT_TMB = 0;
  localparam int GNT_ALCT = 1;
  localparam int GNT_CFEB = 2;
  function automatic logic [2:0] vote3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/gtrg_readout_seq_grant_timer.sv
// gtrg_readout_seq_grant_timer: loadable grant timeout down-counter; a zero load value never expires
module gtrg_readout_seq_grant_timer #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST_B,
  input  logic         LOAD,
  input  logic         EN,
  input  logic         CLR,
  input  logic [W-1:0] VAL,
  output logic         EXPIRED
);
  logic [W-1:0] cnt;
  logic         armed;
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      cnt <= '0;
      armed <= 1'b0;
    end else if (CLR) begin
      cnt <= '0;
      armed <= 1'b0;
    end else if (LOAD) begin
      cnt <= VAL;
      armed <= |VAL;
    end else if (EN && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
  // Fires in the cycle whose edge takes the count to zero, so a load of N grants exactly N clocks
  assign EXPIRED = EN && armed && cnt == W'(1);
endmodule

// File: rtl/gtrg_readout_seq.sv
// gtrg_readout_seq: pops one GTRG FIFO entry per event, emits header, grants each flagged source, emits trailer
module gtrg_readout_seq
  import gtrg_readout_seq_pkg::*;
#(
  parameter bit TMR = 1'b0,
  parameter int TMOUT_W = 10
) (
  input  logic               CLK,
  input  logic               RST_B,
  input  logic               EMPTY_B,
  input  logic [16:0]        DAVSOUT,
  input  logic [11:0]        BXCOUNTOUT,
  input  logic [3:0]         CFEBBX,
  output logic               POP,
  input  logic               L1ARST,
  input  logic [TMOUT_W-1:0] TMOUT,
  output logic [6:0]         RDGNT,
  input  logic [6:0]         RDDONE,
  output logic [15:0]        DOUT,
  output logic               DOUT_VLD,
  input  logic               DOUT_RDY,
  output logic               BUSY,
  output logic               TMOERR,
  output logic [23:0]        L1ACNT
);
  state_t      state, nxt;
  logic [16:0] davs;
  logic [11:0] bx;
  logic [3:0]  cbx;
  logic [6:0]  pend, flags, pick, dav_map;
  logic [1:0]  widx;
  logic [15:0] hdr_word, trl_word;
  logic        xfer, done, expired, fin;
  assign xfer = DOUT_VLD & DOUT_RDY;
  assign pick = pend & (~pend + 7'd1);
  assign done = (state == S_WAIT_DN) && |(RDDONE & RDGNT);
  assign fin = (state == S_WAIT_DN) && (done || expired);
  assign POP = state == S_LATCH;
  assign BUSY = state != S_IDLE;
  assign hdr_word = widx == 2'd0 ? {TAG_L1A, L1ACNT[11:0]} :
                    widx == 2'd1 ? {TAG_L1A, L1ACNT[23:12]} :
                    widx == 2'd2 ? {TAG_BX, bx} :
                    {TAG_BX, 1'b0, davs[16], davs[0], davs[5:1], cbx};
  assign trl_word = widx[0] ? {TAG_FLG, flags, 5'b0} : {TAG_TRL, davs[15:11], davs[10:6], 2'b00};
  always_comb begin
    dav_map = '0;
    dav_map[GNT_TMB] = DAVSOUT[0];
    dav_map[GNT_ALCT] = DAVSOUT[16];
    dav_map[GNT_CFEB +: 5] = DAVSOUT[5:1];
  end
  gtrg_readout_seq_grant_timer #(.W(TMOUT_W)) u_tmr (
    .CLK     (CLK),
    .RST_B   (RST_B),
    .LOAD    (state == S_SCAN),
    .EN      (state == S_WAIT_DN),
    .CLR     (state == S_IDLE),
    .VAL     (TMOUT),
    .EXPIRED (expired)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    nxt = EMPTY_B ? S_WAIT_RD : S_IDLE;
      S_WAIT_RD: nxt = S_LATCH;
      S_LATCH:   nxt = S_HDR;
      S_HDR:     nxt = xfer && widx == 2'd3 ? S_SCAN : S_HDR;
      S_SCAN:    nxt = pend == '0 ? S_TRL : S_WAIT_DN;
      S_WAIT_DN: nxt = fin ? S_SCAN : S_WAIT_DN;
      S_TRL:     nxt = xfer && widx == 2'd1 ? S_IDLE : S_TRL;
      default:   nxt = S_IDLE;
    endcase
  end
  generate
    if (TMR) begin : g_tmr
      logic [2:0] st0, st1, st2;
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          st0 <= S_IDLE;
          st1 <= S_IDLE;
          st2 <= S_IDLE;
        end else begin
          st0 <= nxt;
          st1 <= nxt;
          st2 <= nxt;
        end
      end
      assign state = state_t'(vote3(st0, st1, st2));
    end else begin : g_one
      state_t st;
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) st <= S_IDLE;
        else st <= nxt;
      end
      assign state = st;
    end
  endgenerate
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      davs <= '0;
      bx <= '0;
      cbx <= '0;
      pend <= '0;
      flags <= '0;
      widx <= '0;
      RDGNT <= '0;
      TMOERR <= 1'b0;
      DOUT <= '0;
      DOUT_VLD <= 1'b0;
      L1ACNT <= '0;
    end else begin
      L1ACNT <= state == S_LATCH ? (L1ARST ? 24'd1 : L1ACNT + 24'd1) : L1ARST ? 24'd0 : L1ACNT;
      TMOERR <= fin && !done;
      if (state == S_LATCH) begin
        davs <= DAVSOUT;
        bx <= BXCOUNTOUT;
        cbx <= CFEBBX;
        pend <= dav_map;
        flags <= '0;
        widx <= '0;
      end
      if (state == S_SCAN) RDGNT <= pick;
      if (fin) begin
        RDGNT <= '0;
        pend <= pend & ~RDGNT;
        flags <= done ? flags : flags | RDGNT;
      end
      // One idle cycle after every transfer before the next word is presented
      if (xfer) begin
        DOUT_VLD <= 1'b0;
        widx <= widx + 2'd1;
      end else if (!DOUT_VLD && (state == S_HDR || state == S_TRL)) begin
        DOUT_VLD <= 1'b1;
        DOUT <= state == S_HDR ? hdr_word : trl_word;
      end
    end
  end
endmodule
